// File: rtl/rtr_pkg.sv
// Shared types and constants for the serial router receive deserializer.
package rtr_pkg;

  localparam int unsigned ADDR_BITS = 4;
  localparam int unsigned BYTE_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StPad,
    StPayload
  } rx_state_e;

  typedef struct packed {
    logic [ADDR_BITS-1:0] da;
    logic [BYTE_BITS-1:0] data;
    logic                 sop;
    logic                 eop;
  } fifo_entry_t;

endpackage

// File: rtl/rtr_rx_deser_if.sv
// Byte stream leaving the deserializer: head-of-FIFO entry with valid/ready handshake.
interface rtr_rx_deser_if;
  import rtr_pkg::*;

  logic [ADDR_BITS-1:0] out_da;
  logic [BYTE_BITS-1:0] out_data;
  logic                 out_sop;
  logic                 out_eop;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_da, out_data, out_sop, out_eop, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_da, out_data, out_sop, out_eop, out_valid,
    output out_ready
  );

endinterface

// File: rtl/rtr_sync_fifo.sv
// Single-clock FIFO; a read on a full FIFO frees the slot for a same-cycle write.
module rtr_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             wr_ok, rd_ok;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(wr_ok) - CntW'(rd_ok);
    end
  end

endmodule

// File: rtl/rtr_rx_deser.sv
// Serial packet receiver: address, pad gap, LSB-first payload bytes pushed into a byte FIFO.
module rtr_rx_deser
  import rtr_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PAD_CYCLES = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           din,
  input  logic           frame_n,
  input  logic           valid_n,
  output logic           busy_n,
  output logic           out_err,
  rtr_rx_deser_if.master out_if
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned BitW = $clog2(BYTE_BITS);
  localparam int unsigned PadW = (PAD_CYCLES > 1) ? $clog2(PAD_CYCLES) : 1;

  rx_state_e            state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [BYTE_BITS-1:0] shift_q, shift_d;
  logic [BitW-1:0]      bit_cnt_q;
  logic [PadW-1:0]      pad_cnt_q;
  logic                 sop_q, err_q, busy_q;

  fifo_entry_t          wr_entry, rd_entry;
  logic                 full, empty;
  logic [CntW-1:0]      count, count_nxt;
  logic                 byte_done, rd_fire, wr_accept;

  assign shift_d   = {din, shift_q[BYTE_BITS-1:1]};
  assign byte_done = (state_q == StPayload) && !valid_n && (bit_cnt_q == BitW'(BYTE_BITS - 1));
  assign rd_fire   = !empty && out_if.out_ready;
  assign wr_accept = byte_done && (!full || rd_fire);
  assign count_nxt = count + CntW'(wr_accept) - CntW'(rd_fire);

  assign wr_entry = '{da: addr_q, data: shift_d, sop: sop_q, eop: frame_n};

  rtr_sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (byte_done),
    .wr_data (wr_entry),
    .rd_en   (out_if.out_ready),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pad_cnt_q <= '0;
      sop_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      err_q  <= 1'b0;
      busy_q <= (count_nxt < CntW'(DEPTH - 1));
      unique case (state_q)
        StIdle: begin
          if (!frame_n) begin
            addr_q[0] <= din;
            bit_cnt_q <= BitW'(1);
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (frame_n) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            addr_q[bit_cnt_q[1:0]] <= din;
            if (bit_cnt_q == BitW'(ADDR_BITS - 1)) begin
              bit_cnt_q <= '0;
              pad_cnt_q <= '0;
              sop_q     <= 1'b1;
              state_q   <= (PAD_CYCLES == 0) ? StPayload : StPad;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
        end
        StPad: begin
          if (frame_n) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if (pad_cnt_q == PadW'(PAD_CYCLES - 1)) begin
            state_q <= StPayload;
          end else begin
            pad_cnt_q <= pad_cnt_q + PadW'(1);
          end
        end
        StPayload: begin
          // Bit counter wraps 7 -> 0 on byte completion; gap cycles leave it untouched.
          if (!valid_n) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + BitW'(1);
          end
          if (byte_done) begin
            sop_q <= 1'b0;
            if (!wr_accept) err_q <= 1'b1;
          end
          // Frame end without a completing bit leaves a partial byte: flag and abandon it.
          if (frame_n) begin
            state_q <= StIdle;
            if (!byte_done) err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_n  = busy_q;
  assign out_err = err_q;

  assign out_if.out_valid = !empty;
  assign out_if.out_da    = rd_entry.da;
  assign out_if.out_data  = rd_entry.data;
  assign out_if.out_sop   = rd_entry.sop;
  assign out_if.out_eop   = rd_entry.eop;

endmodule

// File: tb/tb_rtr_rx_deser.sv
// Directed self-checking bench for rtr_rx_deser (DEPTH=4, PAD_CYCLES=5).
module tb_rtr_rx_deser;

  localparam int unsigned PAD = 5;

  logic clk;
  logic reset_n;
  logic din, frame_n, valid_n;
  logic busy_n, out_err;
  int   tests, failed, err_cnt;

  rtr_rx_deser_if bus ();

  rtr_rx_deser #(
    .DEPTH      (4),
    .PAD_CYCLES (PAD)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .frame_n (frame_n),
    .valid_n (valid_n),
    .busy_n  (busy_n),
    .out_err (out_err),
    .out_if  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (out_err === 1'b1) err_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then let one rising edge consume them; returns at the next falling edge.
  task automatic drive(input logic d, input logic f, input logic v);
    din = d; frame_n = f; valid_n = v;
    @(negedge clk);
  endtask

  task automatic send_hdr(input logic [3:0] da);
    for (int i = 0; i < 4; i++) drive(da[i], 1'b0, 1'b1);
    for (int i = 0; i < PAD; i++) drive(1'b1, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic [7:0] gaps,
                           input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gaps[i]) drive(~b[i], 1'b0, 1'b1);
      drive(b[i], last && (i == 7), 1'b0);
    end
  endtask

  task automatic pop(input string tag, input logic [3:0] da, input logic [7:0] d,
                     input logic s, input logic e);
    check(tag, {bus.out_valid, bus.out_da, bus.out_data, bus.out_sop, bus.out_eop},
          {1'b1, da, d, s, e});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    tests = 0; failed = 0; err_cnt = 0;
    reset_n = 1'b0; din = 1'b0; frame_n = 1'b1; valid_n = 1'b1; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.out_valid, out_err, bus.out_sop, bus.out_eop, bus.out_data,
                          bus.out_da, busy_n}, {4'b0000, 8'h00, 4'h0, 1'b1});
    reset_n = 1'b1;

    // da=5, A5 then 3C, no gaps
    send_hdr(4'h5);
    check("valid_before_payload", bus.out_valid, 1'b0);
    send_byte(8'hA5, 1'b0, 8'h00, 7);
    check("valid_before_8th_bit", bus.out_valid, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    check("valid_1cyc_after_write", bus.out_valid, 1'b1);
    send_byte(8'h3C, 1'b1, 8'h00, 8);
    drive(1'b0, 1'b1, 1'b1);
    pop("pkt1_b0", 4'h5, 8'hA5, 1'b1, 1'b0);
    pop("pkt1_b1", 4'h5, 8'h3C, 1'b0, 1'b1);
    check("pkt1_drained", bus.out_valid, 1'b0);
    check("pkt1_no_err", err_cnt, 0);

    // da=9, 0x81 with three valid_n-high gaps mid-byte
    send_hdr(4'h9);
    send_byte(8'h81, 1'b1, 8'b0001_0110, 8);
    drive(1'b0, 1'b1, 1'b1);
    pop("gap_byte", 4'h9, 8'h81, 1'b1, 1'b1);
    check("gap_drained", bus.out_valid, 1'b0);

    // Backpressure: 4 bytes fill DEPTH=4 exactly
    send_hdr(4'h3);
    send_byte(8'h11, 1'b0, 8'h00, 8);
    check("busy_after_1", busy_n, 1'b1);
    send_byte(8'h22, 1'b0, 8'h00, 8);
    check("busy_after_2", busy_n, 1'b1);
    send_byte(8'h33, 1'b0, 8'h00, 8);
    check("busy_after_3", busy_n, 1'b0);
    send_byte(8'h44, 1'b1, 8'h00, 8);
    check("busy_after_4", busy_n, 1'b0);
    check("full_no_err", out_err, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check("full_err_cnt", err_cnt, 0);
    pop("full_b0", 4'h3, 8'h11, 1'b1, 1'b0);
    check("busy_at_count3", busy_n, 1'b0);
    pop("full_b1", 4'h3, 8'h22, 1'b0, 1'b0);
    check("busy_at_count2", busy_n, 1'b1);
    pop("full_b2", 4'h3, 8'h33, 1'b0, 1'b0);
    pop("full_b3", 4'h3, 8'h44, 1'b0, 1'b1);

    // 5 bytes into DEPTH=4: last one dropped with an error pulse
    send_hdr(4'h6);
    send_byte(8'h55, 1'b0, 8'h00, 8);
    send_byte(8'h66, 1'b0, 8'h00, 8);
    send_byte(8'h77, 1'b0, 8'h00, 8);
    send_byte(8'h88, 1'b0, 8'h00, 8);
    check("ovf_no_err_yet", out_err, 1'b0);
    send_byte(8'h99, 1'b1, 8'h00, 8);
    check("ovf_err_pulse", out_err, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    check("ovf_err_one_cycle", out_err, 1'b0);
    pop("ovf_b0", 4'h6, 8'h55, 1'b1, 1'b0);
    pop("ovf_b1", 4'h6, 8'h66, 1'b0, 1'b0);
    pop("ovf_b2", 4'h6, 8'h77, 1'b0, 1'b0);
    pop("ovf_b3", 4'h6, 8'h88, 1'b0, 1'b0);
    check("ovf_dropped", bus.out_valid, 1'b0);
    check("ovf_err_cnt", err_cnt, 1);

    // Frame aborted after 2 address bits, then a clean packet
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    check("addr_abort_err", out_err, 1'b1);
    check("addr_abort_nowrite", bus.out_valid, 1'b0);
    send_hdr(4'hC);
    send_byte(8'h5A, 1'b1, 8'h00, 8);
    drive(1'b0, 1'b1, 1'b1);
    pop("after_abort", 4'hC, 8'h5A, 1'b1, 1'b1);

    // Frame ends 5 bits into the second byte
    send_hdr(4'h2);
    send_byte(8'hF0, 1'b0, 8'h00, 8);
    send_byte(8'h1F, 1'b0, 8'h00, 5);
    drive(1'b0, 1'b1, 1'b1);
    check("partial_err", out_err, 1'b1);
    pop("partial_b0", 4'h2, 8'hF0, 1'b1, 1'b0);
    check("partial_discarded", bus.out_valid, 1'b0);
    check("total_err_cnt", err_cnt, 3);

    // Reset mid-payload with two bytes buffered
    send_hdr(4'h7);
    send_byte(8'h12, 1'b0, 8'h00, 8);
    send_byte(8'h34, 1'b0, 8'h00, 8);
    send_byte(8'h56, 1'b0, 8'h00, 3);
    check("pre_rst_valid", bus.out_valid, 1'b1);
    #2;
    reset_n = 1'b0; din = 1'b0; frame_n = 1'b1; valid_n = 1'b1;
    #1;
    check("async_rst_valid", bus.out_valid, 1'b0);
    check("async_rst_busy", busy_n, 1'b1);
    @(negedge clk);
    check("rst_no_err", out_err, 1'b0);
    reset_n = 1'b1;
    send_hdr(4'hE);
    send_byte(8'h96, 1'b1, 8'h00, 8);
    drive(1'b0, 1'b1, 1'b1);
    pop("post_rst", 4'hE, 8'h96, 1'b1, 1'b1);
    check("post_rst_drained", bus.out_valid, 1'b0);
    check("final_err_cnt", err_cnt, 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
